apb_slave_mem: RTL
==================

Name: apb_slave_mem

Overview:
- APB3 completer memory directly downstream of the APB master bridge.
- The bridge turns transfer/READ_WRITE requests into PSEL/PENABLE bus cycles; this block answers them.
- It returns read data to the bridge, which forwards it as apb_read_data_out, and flags errors on PSLVERR.
- Wait-state insertion is programmable so the bridge's PREADY handling is exercised.

Parameters:
- ADDR_WIDTH, 9: PADDR width. The MSB is the slave-select bit, decoded upstream and ignored here.
- DATA_WIDTH, 8: PWDATA/PRDATA width.
- MEM_DEPTH, 192: number of implemented words. Index ≥ MEM_DEPTH is out of range.
- WAIT_CYCLES, 2: PREADY-low cycles inserted in every access phase; 0 means zero-wait.

Ports:
- PCLK  in  1  bus clock, rising-edge.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address; index = PADDR[ADDR_WIDTH-2:0].
- PWDATA  in  DATA_WIDTH  write data.
- PREADY  out  1  transfer completes in this cycle.
- PRDATA  out  DATA_WIDTH  read data, valid when PREADY=1 and PWRITE=0.
- PSLVERR  out  1  error response, valid only with PREADY=1.

Behaviour:
- One clock (PCLK); reset is asynchronous and active-low (PRESETn).
- Reset (PRESETn=0, asynchronous): state=IDLE, cnt=0, PREADY=0, PSLVERR=0, PRDATA=0, every memory word = 0.
- FSM has two states, IDLE and ACCESS.
- IDLE:
  - At a rising edge with PSEL=1 and PENABLE=0 (setup phase), latch addr_q, wr_q, wdata_q.
  - Also latch err_q = (index ≥ MEM_DEPTH) and load cnt=WAIT_CYCLES, then go to ACCESS.
  - On a read with err_q=0, PRDATA is loaded with mem[index] at this same edge. On a read with err_q=1, PRDATA=0.
  - PSEL=1 with PENABLE=1 seen in IDLE is a protocol violation: ignore it, stay in IDLE, never assert PREADY.
- ACCESS:
  - PREADY = (state==ACCESS && cnt==0). It is decoded from registers only, never from bus inputs.
  - PSLVERR = PREADY & err_q. Outside PREADY=1 it is held at 0.
  - At an edge with PSEL=1, PENABLE=1 and cnt≠0: cnt decrements.
  - At an edge with PSEL=1, PENABLE=1 and cnt==0: the transfer completes.
    - If wr_q=1 and err_q=0, write mem[index]=wdata_q.
    - A write with err_q=1 is dropped and memory is unchanged.
    - The next state is IDLE.
  - At an edge with PSEL=0 (master abort): go to IDLE with no write and no response. PRDATA holds.
  - PENABLE=0 with PSEL=1 while in ACCESS (new setup with no completion) is treated as an abort followed by a new setup.
- Latency:
  - A transfer spans exactly 2+WAIT_CYCLES PCLK cycles from setup to completion.
  - Back-to-back transfers run with no idle cycle between them: the completion edge can be followed directly by a setup.
- PRDATA holds its last loaded value between reads. It is not updated by writes.
- A read issued immediately after a write to the same index returns the new data, because the write commits before the read's setup edge.
- Reset asserted mid-transfer: immediately IDLE, PREADY=0. A pending write is lost and memory is cleared.
- PWDATA, PADDR and PWRITE changes during the access phase are ignored, since values were latched at setup.

Test Plan:
- Reset, then read index 0x05 with WAIT_CYCLES=2 → PREADY low for 2 access cycles, high in the 3rd; PRDATA=0x00; PSLVERR=0.
- Write 0xA5 to 0x010, then an immediate back-to-back read of 0x010 → read completes with PRDATA=0xA5, PSLVERR=0. The total for both transfers is 8 cycles.
- Write 0x3C to index 0xC8 (≥192) → PREADY=1 with PSLVERR=1. A follow-up read of 0xC8 returns PRDATA=0x00 with PSLVERR=1. Memory is unchanged.
- Rebuild with WAIT_CYCLES=0: write 0x11 to 0x000 then read it → each transfer takes 2 cycles, PREADY=1 on the first access cycle, PRDATA=0x11.
- Drop PSEL after one wait cycle during a write of 0x77 to 0x020 → no PREADY. A subsequent read of 0x020 returns the old value 0x00.
- Assert PRESETn=0 mid-wait during a write of 0xFF to 0x030 → PREADY=0 at once. After release, a read of 0x030 returns 0x00. A PENABLE=1 driven in IDLE without a setup phase never produces PREADY.

Source files
------------

// File: rtl/apb_slave_mem.sv
// APB3 completer memory with programmable wait states and an out-of-range error response.
// Address, direction and write data are captured at the setup edge. Read data is loaded at that same edge.
module apb_slave_mem #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 8,
    parameter int MEM_DEPTH   = 192,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR
);

    localparam int IDX_W = ADDR_WIDTH - 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    logic [0:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      addr_q;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [IDX_W-1:0]      idx;
    logic                  idx_err;
    logic                  setup;
    logic                  complete;
    logic                  unused_addr_msb;

    // The PADDR MSB is the slave select, which is decoded upstream.
    assign unused_addr_msb = PADDR[ADDR_WIDTH-1];
    assign idx             = PADDR[IDX_W-1:0];
    assign idx_err         = (32'(idx) >= 32'(MEM_DEPTH));

    // A setup seen while in ACCESS aborts the current transfer and restarts on the new one.
    assign setup    = PSEL && !PENABLE;
    assign complete = (state == ACCESS) && PSEL && PENABLE && (cnt == '0);

    assign PREADY  = (state == ACCESS) && (cnt == '0);
    assign PSLVERR = PREADY && err_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            PRDATA  <= '0;
        end else if (setup) begin
            addr_q  <= idx;
            wr_q    <= PWRITE;
            wdata_q <= PWDATA;
            err_q   <= idx_err;
            cnt     <= CNT_W'(WAIT_CYCLES);
            state   <= ACCESS;
            if (!PWRITE) begin
                PRDATA <= idx_err ? '0 : mem[idx];
            end
        end else if (state == ACCESS) begin
            if (!PSEL) begin
                state <= IDLE;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else begin
                state <= IDLE;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (complete && wr_q && !err_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

endmodule
